// File: rtl/tick_sched_pkg.sv
// Shared encodings for tick_scheduler: configuration opcodes and channel states.
// Pure definitions; no logic, no latency, no flow control.
package tick_sched_pkg;

  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_PERIODIC = 2'b01;
  localparam logic [1:0] CMD_ONESHOT  = 2'b10;
  localparam logic [1:0] CMD_RSVD     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PERIODIC = 2'd1,
    ST_ONESHOT  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a base_tick every PRESCALE enabled cycles.
// base_tick is combinational from the count; en low freezes it, no backpressure.
module tick_prescaler #(
  parameter int PRESCALE = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic base_tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Masked during reset so the strobe is quiet while the count is being cleared.
  assign base_tick = en && !rst && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// NUM_CH timer channels (stop/periodic/one-shot) sharing one prescaler; ch_tick is registered (1 cycle).
// Commands take effect on the next edge; cfg_ready is low only during reset.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = 50_000,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                cfg_cmd,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic                      base_tick,
  output logic [NUM_CH-1:0]         ch_tick,
  output logic [NUM_CH-1:0]         ch_active
);

  localparam int CHW = $clog2(NUM_CH);

  logic cfg_fire;

  assign cfg_ready = !rst;
  assign cfg_fire  = cfg_valid && cfg_ready;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .base_tick (base_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             tick_q, tick_d;
    logic             hit;

    assign hit = cfg_fire && (cfg_ch == CHW'(i));

    // A command for this channel pre-empts any base_tick landing in the same cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      tick_d  = 1'b0;
      if (hit) begin
        case (cfg_cmd)
          CMD_STOP: state_d = ST_IDLE;
          CMD_PERIODIC, CMD_ONESHOT: begin
            if (cfg_period == '0) begin
              state_d = ST_IDLE;
            end else begin
              per_d   = cfg_period;
              cnt_d   = cfg_period;
              state_d = (cfg_cmd == CMD_ONESHOT) ? ST_ONESHOT : ST_PERIODIC;
            end
          end
          CMD_RSVD: begin
          end
        endcase
      end else if (base_tick && (state_q != ST_IDLE)) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          tick_d = 1'b1;
          if (state_q == ST_ONESHOT) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = per_q;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        tick_q  <= tick_d;
      end
    end

    assign ch_tick[i]   = tick_q;
    assign ch_active[i] = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized scoreboard bench for tick_scheduler (PRESCALE=4, NUM_CH=2, CNT_W=8).
// The reference model tracks absolute base-tick deadlines rather than countdowns.
module tb_tick_scheduler;

  localparam int PRESCALE = 4;
  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;

  logic              clk = 1'b0;
  logic              rst, en, cfg_valid, cfg_ready, base_tick;
  logic [0:0]        cfg_ch;
  logic [1:0]        cfg_cmd;
  logic [CNT_W-1:0]  cfg_period;
  logic [NUM_CH-1:0] ch_tick, ch_active;

  tick_scheduler #(
    .PRESCALE (PRESCALE),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_cmd    (cfg_cmd),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .ch_tick    (ch_tick),
    .ch_active  (ch_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              base;
    bit [NUM_CH-1:0] act;
    bit              ready;
  } exp_t;

  exp_t expq[$];
  int   tickq[NUM_CH][$];
  exp_t mx;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: enabled-cycle count, base-tick count and per-channel deadlines.
  int ecnt = 0;
  int btn  = 0;
  bit m_act [NUM_CH];
  bit m_one [NUM_CH];
  int m_per [NUM_CH];
  int m_dl  [NUM_CH];
  bit m_pend[NUM_CH];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, got, req);
    end
  endtask

  function automatic bit bt_now(input bit r, input bit e);
    return !r && e && ((ecnt % PRESCALE) == PRESCALE - 1);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit v,
                            input int ch, input int cmd, input int p);
    exp_t x;
    bit   bt;
    bit   npend[NUM_CH];
    bt      = bt_now(r, e);
    x.base  = bt;
    x.ready = !r;
    for (int i = 0; i < NUM_CH; i++) begin
      x.act[i] = m_act[i];
      if (m_pend[i]) tickq[i].push_back(cyc);
    end
    expq.push_back(x);
    if (r) begin
      ecnt = 0;
      btn  = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_act[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      npend[i] = 1'b0;
      if (v && ch == i) begin
        case (cmd)
          0: m_act[i] = 1'b0;
          1, 2: begin
            if (p == 0) begin
              m_act[i] = 1'b0;
            end else begin
              m_act[i] = 1'b1;
              m_one[i] = (cmd == 2);
              m_per[i] = p;
              m_dl[i]  = btn + (bt ? 1 : 0) + p;
            end
          end
          default: if (bt && m_act[i]) m_dl[i]++;
        endcase
      end else if (bt && m_act[i] && (btn + 1 == m_dl[i])) begin
        npend[i] = 1'b1;
        if (m_one[i]) m_act[i] = 1'b0;
        else          m_dl[i]  = m_dl[i] + m_per[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) m_pend[i] = npend[i];
    if (bt) btn++;
    if (e)  ecnt++;
  endtask

  task automatic drive(input bit r, input bit e, input bit v,
                       input int ch, input int cmd, input int p);
    rst        = r;
    en         = e;
    cfg_valid  = v;
    cfg_ch     = 1'(ch);
    cfg_cmd    = 2'(cmd);
    cfg_period = CNT_W'(p);
    model_step(r, e, v, ch, cmd, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit e = 1'b1);
    repeat (n) drive(1'b0, e, 1'b0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mx = expq.pop_front();
      check("base_tick", 32'(base_tick), 32'(mx.base));
      check("ch_active", 32'(ch_active), 32'(mx.act));
      check("cfg_ready", 32'(cfg_ready), 32'(mx.ready));
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_tick[i] !== 1'b0) begin
          if (tickq[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ch_tick[%0d] at cycle %0d: got %b, required 0", i, cyc, ch_tick[i]);
          end else begin
            check("ch_tick_cycle", cyc, tickq[i].pop_front());
          end
        end else if (tickq[i].size() > 0 && tickq[i][0] == cyc) begin
          void'(tickq[i].pop_front());
          check("ch_tick_missing", 32'(ch_tick[i]), 32'd1);
        end
      end
    end
  end

  int guard;

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_cmd = '0; cfg_period = '0;
    @(posedge clk);
    #1;
    // Checked reset cycle with a command offered that must be dropped.
    drive(1'b1, 1'b1, 1'b1, 0, 1, 3);

    idle(12);
    drive(1'b0, 1'b1, 1'b1, 0, 1, 3);
    drive(1'b0, 1'b1, 1'b1, 1, 2, 2);
    guard = 0;
    while (!bt_now(1'b0, 1'b1) && guard < 8) begin
      idle(1);
      guard++;
    end
    drive(1'b0, 1'b1, 1'b1, 1, 2, 1);
    idle(2);
    drive(1'b0, 1'b1, 1'b1, 0, 0, 0);
    idle(30);
    drive(1'b0, 1'b1, 1'b1, 1, 1, 0);
    idle(5);
    drive(1'b0, 1'b1, 1'b1, 0, 3, 0);
    drive(1'b0, 1'b1, 1'b1, 0, 1, 1);
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 0, 3, 7);
    idle(10);
    idle(5, 1'b0);
    idle(12);
    drive(1'b0, 1'b1, 1'b1, 1, 1, 2);
    idle(6);
    drive(1'b1, 1'b1, 1'b1, 0, 1, 5);
    idle(20);

    repeat (3000) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 5));
    end
    idle(4);

    for (int i = 0; i < NUM_CH; i++) check("tick_queue_drained", tickq[i].size(), 0);
    check("exp_queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
